random_number_gen: RTL

Parametrised successor to the lab 4-bit button counter. While `button` is held, an internal generator advances once per clock. On release, the generator value is captured into `random_number` and announced with a one-cycle `number_valid` pulse. The generator is either a wrapping counter with a programmable maximum or a maximal-length LFSR. The block sits between the synchronised/debounced button path and the display/game logic.

---
 rtl/random_number_gen.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/random_number_gen.sv
// random_number_gen
//   Rolls a value while the button is held and publishes it on release.
//   The internal generator advances once per clock for every sampled high
//   button; on the ROLLING -> IDLE transition the generator value is latched
//   into random_number and announced with a one-cycle number_valid pulse.
//   The generator is either a wrapping counter (MODE=0) or a maximal-length
//   Fibonacci LFSR (MODE=1).
//
// Parameters
//   WIDTH      generator / output width (3..8 for the LFSR)
//   MAX_VALUE  counter-mode wrap limit (0..2^WIDTH-1)
//   MODE       0 = wrapping counter, 1 = Fibonacci LFSR
//   SEED       LFSR reset value; 0 is replaced by 1
//
// Ports
//   clock          in   system clock, rising edge active
//   reset          in   asynchronous, active-low reset
//   button         in   active-high roll request, synchronous to clock
//   random_number  out  last captured generator value (registered)
//   number_valid   out  one-cycle pulse when random_number updates
//   rolling        out  high while the FSM is in ROLLING
//   roll_count     out  completed rolls since reset, saturating at 255

module random_number_gen #(
    parameter int unsigned WIDTH     = 4,
    parameter int unsigned MAX_VALUE = 15,
    parameter int unsigned MODE      = 0,
    parameter int unsigned SEED      = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             button,
    output logic [WIDTH-1:0] random_number,
    output logic             number_valid,
    output logic             rolling,
    output logic [7:0]       roll_count
);

    // Feedback taps for a maximal-length sequence at each supported width.
    function automatic logic [31:0] tap_mask(input int unsigned w);
        case (w)
            3:       tap_mask = 32'h0000_0006;
            4:       tap_mask = 32'h0000_000C;
            5:       tap_mask = 32'h0000_0014;
            6:       tap_mask = 32'h0000_0030;
            7:       tap_mask = 32'h0000_0060;
            8:       tap_mask = 32'h0000_00B8;
            default: tap_mask = '0;
        endcase
    endfunction

    localparam logic [WIDTH-1:0] TAPS   = WIDTH'(tap_mask(WIDTH));
    localparam logic [WIDTH-1:0] MAX_W  = WIDTH'(MAX_VALUE);
    // An all-zero seed would lock the LFSR, so it is forced to 1.
    localparam logic [WIDTH-1:0] SEED_W = (WIDTH'(SEED) == '0) ? WIDTH'(1) : WIDTH'(SEED);
    localparam logic [WIDTH-1:0] GEN_RESET = (MODE == 1) ? SEED_W : '0;

    if (MODE > 1) begin : g_bad_mode
        $error("random_number_gen: MODE must be 0 or 1");
    end
    if (MODE == 1 && (WIDTH < 3 || WIDTH > 8)) begin : g_bad_width
        $error("random_number_gen: LFSR mode supports WIDTH 3..8 only");
    end
    if ((MAX_VALUE >> WIDTH) != 0) begin : g_bad_max
        $error("random_number_gen: MAX_VALUE exceeds 2^WIDTH-1");
    end

    typedef enum logic {
        IDLE    = 1'b0,
        ROLLING = 1'b1
    } state_t;

    state_t           state;
    state_t           state_next;
    logic             capture;
    logic [WIDTH-1:0] gen;
    logic [WIDTH-1:0] gen_next;

    // FSM next state and capture strobe.
    always_comb begin
        state_next = state;
        capture    = 1'b0;
        case (state)
            IDLE: begin
                if (button) begin
                    state_next = ROLLING;
                end
            end
            ROLLING: begin
                if (!button) begin
                    state_next = IDLE;
                    capture    = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Generator successor value; applied only on edges that sample button=1.
    always_comb begin
        gen_next = gen;
        if (MODE == 1) begin
            gen_next = {gen[WIDTH-2:0], ^(gen & TAPS)};
        end else if (gen == MAX_W) begin
            gen_next = '0;
        end else begin
            gen_next = gen + WIDTH'(1);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            gen <= GEN_RESET;
        end else if (button) begin
            gen <= gen_next;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            random_number <= '0;
            number_valid  <= 1'b0;
            roll_count    <= '0;
        end else begin
            number_valid <= 1'b0;
            if (capture) begin
                random_number <= gen;
                number_valid  <= 1'b1;
                if (roll_count != 8'hFF) begin
                    roll_count <= roll_count + 8'd1;
                end
            end
        end
    end

    assign rolling = (state == ROLLING);

endmodule
